// File: rtl/i2s_adc_rx.sv
`default_nettype none
// ============================================================================
// Module      : i2s_adc_rx
// Description : I2S slave receiver. Oversamples BCLK/LRCK/SDIN in the clk
//               domain and presents left/right sample pairs on valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_adc_rx #(
    parameter int DATA_W = 24,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i2s_bclk,
    input  logic              i2s_lrck,
    input  logic              i2s_sdin,
    output logic [DATA_W-1:0] left_data,
    output logic [DATA_W-1:0] right_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun,
    output logic              aligned
);

    localparam int               IDX_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_ALIGN = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_t;

    logic [1:0]        r_bclk_sync;
    logic [1:0]        r_lrck_sync;
    logic [1:0]        r_sdin_sync;
    logic              r_bclk_hist;
    logic              r_lrck_prev;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_word;
    logic [DATA_W-1:0] r_left_hold;
    logic [DATA_W-1:0] r_right_hold;
    logic              r_pair_stb;
    state_t            r_state;

    logic              w_rise;
    logic              w_lrck;
    logic              w_sdin;
    logic              w_change;
    logic              w_bit_fits;
    logic [31:0]       w_cnt32;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_final;

    assign w_rise     = r_bclk_sync[1] & ~r_bclk_hist;
    assign w_lrck     = r_lrck_sync[1];
    assign w_sdin     = r_sdin_sync[1];
    assign w_change   = w_rise & (w_lrck != r_lrck_prev);
    assign w_cnt32    = {{(32-CNT_W){1'b0}}, r_cnt};
    assign w_bit_fits = (w_cnt32 < 32'(DATA_W));
    assign w_idx      = IDX_W'(32'(DATA_W - 1) - w_cnt32);

    // Current word with this event's bit merged in; on a channel change this
    // is the finished outgoing word (its LSB slot arrives with the change).
    always_comb begin
        w_final = r_word;
        if (w_bit_fits) begin
            w_final[w_idx] = w_sdin;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bclk_sync <= 2'b00;
            r_lrck_sync <= 2'b00;
            r_sdin_sync <= 2'b00;
            r_bclk_hist <= 1'b0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[0], i2s_bclk};
            r_lrck_sync <= {r_lrck_sync[0], i2s_lrck};
            r_sdin_sync <= {r_sdin_sync[0], i2s_sdin};
            r_bclk_hist <= r_bclk_sync[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lrck_prev <= 1'b0;
            r_cnt       <= '0;
            r_word      <= '0;
        end else if (w_rise) begin
            r_lrck_prev <= w_lrck;
            if (w_change) begin
                r_word <= '0;
                r_cnt  <= '0;
            end else begin
                r_word <= w_final;
                if (r_cnt != C_CNT_MAX) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_ALIGN;
            r_left_hold  <= '0;
            r_right_hold <= '0;
            r_pair_stb   <= 1'b0;
            left_data    <= '0;
            right_data   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            aligned      <= 1'b0;
        end else begin
            r_pair_stb <= 1'b0;
            if (w_change) begin
                case (r_state)
                    ST_ALIGN: begin
                        if (!w_lrck) begin
                            r_state <= ST_LEFT;
                            aligned <= 1'b1;
                        end
                    end
                    ST_LEFT: begin
                        r_left_hold <= w_final;
                        r_state     <= ST_RIGHT;
                    end
                    ST_RIGHT: begin
                        r_right_hold <= w_final;
                        r_pair_stb   <= 1'b1;
                        r_state      <= ST_LEFT;
                    end
                    default: r_state <= ST_ALIGN;
                endcase
            end

            // A pair arriving while the consumer accepts the held one replaces
            // it without a bubble; otherwise a held pair wins and the new one drops.
            if (r_pair_stb) begin
                if (!sample_valid || sample_ready) begin
                    left_data    <= r_left_hold;
                    right_data   <= r_right_hold;
                    sample_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_adc_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_adc_rx
// Description : Directed scoreboard bench for i2s_adc_rx (BCLK = clk/8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_adc_rx;

    localparam int DATA_W = 24;
    localparam int CNT_W  = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              bclk;
    logic              lrck;
    logic              sdin;
    logic              ready;
    logic [DATA_W-1:0] left_data;
    logic [DATA_W-1:0] right_data;
    logic              valid;
    logic              overrun;
    logic              aligned;

    i2s_adc_rx #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .i2s_bclk     (bclk),
        .i2s_lrck     (lrck),
        .i2s_sdin     (sdin),
        .left_data    (left_data),
        .right_data   (right_data),
        .sample_valid (valid),
        .sample_ready (ready),
        .overrun      (overrun),
        .aligned      (aligned)
    );

    always #5 clk = ~clk;

    // mode 1: valid must still be 0 one cycle before the load
    // mode 2: valid must already be 1 one cycle before the load
    typedef struct {
        logic [23:0] el;
        logic [23:0] er;
        int          due;
        int          mode;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          errors   = 0;
    int          cyc      = 0;
    int          pulse_at = -100;
    logic [23:0] tx_left;
    logic [23:0] tx_right;
    logic        tx_lsb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (cyc == pulse_at) ready = 1'b1;
        else if (cyc == pulse_at + 1) ready = 1'b0;
        if (sb.size() > 0) begin
            e = sb[0];
            if (cyc == e.due - 1 && e.mode == 1) chk("valid_low_before_load", 32'(valid), 32'd0);
            if (cyc == e.due - 1 && e.mode == 2) chk("valid_held_before_load", 32'(valid), 32'd1);
            if (cyc == e.due) begin
                void'(sb.pop_front());
                chk("pair_valid", 32'(valid), 32'd1);
                chk("pair_left", 32'(left_data), 32'(e.el));
                chk("pair_right", 32'(right_data), 32'(e.er));
            end
        end
    endtask

    // One BCLK period: lrck/sdin change with the falling edge, DUT samples on the rise.
    task automatic send_bit(input logic l, input logic d, input bit push, input int mode, input bit pulse);
        bclk = 1'b0;
        lrck = l;
        sdin = d;
        repeat (4) step();
        bclk = 1'b1;
        if (push) begin
            sb.push_back('{el: tx_left, er: tx_right, due: cyc + 4, mode: mode});
            if (pulse) pulse_at = cyc + 3;
        end
        repeat (4) step();
    endtask

    // A slot's first period carries the previous slot's LSB (one-BCLK delay).
    task automatic send_slot(input logic l, input logic [31:0] word, input int nbits,
                             input bit push, input int mode = 1, input bit pulse = 0);
        logic [31:0] al;
        send_bit(l, tx_lsb, push, mode, pulse);
        for (int i = nbits - 1; i >= 1; i--) begin
            send_bit(l, word[i], 1'b0, 0, 1'b0);
        end
        tx_lsb = word[0];
        al = (nbits >= 24) ? (word >> (nbits - 24)) : (word << (24 - nbits));
        if (l) tx_right = al[23:0];
        else   tx_left  = al[23:0];
    endtask

    initial begin
        rst      = 1'b1;
        bclk     = 1'b0;
        lrck     = 1'b1;
        sdin     = 1'b0;
        ready    = 1'b0;
        tx_lsb   = 1'b0;
        tx_left  = '0;
        tx_right = '0;
        repeat (3) step();
        chk("rst_left", 32'(left_data), 32'd0);
        chk("rst_right", 32'(right_data), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_aligned", 32'(aligned), 32'd0);
        rst = 1'b0;

        // Start mid-right channel, then a full frame A5A5A5 / 5A5A5A
        send_slot(1'b1, 32'hFFFF_FFFF, 12, 1'b0);
        chk("aligned_before_fall", 32'(aligned), 32'd0);
        chk("valid_before_fall", 32'(valid), 32'd0);
        send_slot(1'b0, 32'hA5A5_A500, 32, 1'b0);
        chk("aligned_after_fall", 32'(aligned), 32'd1);
        send_slot(1'b1, 32'h5A5A_5A00, 32, 1'b0);
        chk("no_pair_before_full_frame", 32'(valid), 32'd0);
        send_slot(1'b0, 32'h0000_1234, 16, 1'b1, 1);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("accept_clears_valid", 32'(valid), 32'd0);

        // Short 16-bit slots: 0x1234 / 0x8001
        send_slot(1'b1, 32'h0000_8001, 16, 1'b0);
        send_slot(1'b0, 32'hC0FF_EE00, 32, 1'b1, 1);
        chk("short_overrun", 32'(overrun), 32'd0);

        // Accept the held pair exactly on the next pair's load cycle
        send_slot(1'b1, 32'hBEEF_0100, 32, 1'b0);
        send_slot(1'b0, 32'h1357_9B00, 32, 1'b1, 2, 1'b1);
        chk("simul_overrun", 32'(overrun), 32'd0);
        chk("simul_valid", 32'(valid), 32'd1);

        // Backpressure across two frames: both new pairs dropped
        send_slot(1'b1, 32'h2468_AC00, 32, 1'b0);
        send_slot(1'b0, 32'h0F0F_0F00, 32, 1'b0);
        send_slot(1'b1, 32'hF0F0_F000, 32, 1'b0);
        send_slot(1'b0, 32'h7777_7700, 32, 1'b0);
        chk("bp_valid", 32'(valid), 32'd1);
        chk("bp_left", 32'(left_data), 32'hC0FFEE);
        chk("bp_right", 32'(right_data), 32'hBEEF01);
        chk("bp_overrun", 32'(overrun), 32'd1);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("bp_valid_cleared", 32'(valid), 32'd0);
        chk("bp_overrun_sticky", 32'(overrun), 32'd1);

        // Reset in the middle of a left word, then re-align
        send_slot(1'b1, 32'h1111_1100, 32, 1'b0);
        send_slot(1'b0, 32'hABCD_EF00, 12, 1'b1, 1);
        rst = 1'b1;
        step();
        chk("midrst_left", 32'(left_data), 32'd0);
        chk("midrst_right", 32'(right_data), 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_overrun", 32'(overrun), 32'd0);
        chk("midrst_aligned", 32'(aligned), 32'd0);
        rst = 1'b0;
        send_slot(1'b0, 32'h0000_0000, 20, 1'b0);
        send_slot(1'b1, 32'h2222_2200, 32, 1'b0);
        send_slot(1'b0, 32'h3333_3300, 32, 1'b0);
        send_slot(1'b1, 32'h4444_4400, 32, 1'b0);
        chk("midrst_no_pair_yet", 32'(valid), 32'd0);
        send_slot(1'b0, 32'h5555_5500, 32, 1'b1, 1);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
